// File: rtl/fp16pow_seq.sv
// fp16 integer power, right-to-left square-and-multiply, one exponent bit per cycle.
// Optional abort port enabled by defining FP16POW_ABORT_EN.
`ifndef FP16_WIDTH
`define FP16_WIDTH 16
`endif

module fp16mul (
  input  logic [`FP16_WIDTH-1:0] i_a,
  input  logic [`FP16_WIDTH-1:0] i_b,
  output logic [`FP16_WIDTH-1:0] o_p
);

  logic              sa, sb, sp;
  logic [4:0]        ea, eb;
  logic [9:0]        fa, fb;
  logic              a_zero, b_zero;
  logic              a_inf, b_inf;
  logic              a_nan, b_nan;
  logic [21:0]       prod;
  logic signed [7:0] ex;
  logic [9:0]        frac;
  logic              unused_lsb;

  assign sa = i_a[15];
  assign sb = i_b[15];
  assign ea = i_a[14:10];
  assign eb = i_b[14:10];
  assign fa = i_a[9:0];
  assign fb = i_b[9:0];
  assign sp = sa ^ sb;

  // Subnormal inputs are treated as zero
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'd31) && (fa == 10'd0);
  assign b_inf  = (eb == 5'd31) && (fb == 10'd0);
  assign a_nan  = (ea == 5'd31) && (fa != 10'd0);
  assign b_nan  = (eb == 5'd31) && (fb != 10'd0);

  assign prod = {1'b1, fa} * {1'b1, fb};
  assign ex   = $signed({3'b000, ea}) + $signed({3'b000, eb})
              - 8'sd15 + $signed({7'd0, prod[21]});
  assign frac = prod[21] ? prod[20:11] : prod[19:10];
  assign unused_lsb = ^prod[9:0];

  // Truncation is round-toward-zero; too-small results flush to zero
  always_comb begin
    o_p = {sp, ex[4:0], frac};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      o_p = 16'h7E00;
    else if (a_inf || b_inf)
      o_p = {sp, 15'h7C00};
    else if (a_zero || b_zero)
      o_p = {sp, 15'h0000};
    else if (ex >= 8'sd31)
      o_p = {sp, 15'h7C00};
    else if (ex <= 8'sd0)
      o_p = {sp, 15'h0000};
  end

endmodule

module fp16pow_seq #(
  parameter int EXP_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [`FP16_WIDTH-1:0] i_base,
  input  logic [EXP_WIDTH-1:0]   i_exp,
`ifdef FP16POW_ABORT_EN
  input  logic                   i_abort,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic [`FP16_WIDTH-1:0] o_res
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [`FP16_WIDTH-1:0] acc, acc_nxt;
  logic [`FP16_WIDTH-1:0] sq, sq_nxt;
  logic [EXP_WIDTH-1:0]   e, e_nxt;
  logic [`FP16_WIDTH-1:0] res_nxt;
  logic [`FP16_WIDTH-1:0] mul_acc, mul_sq;

  fp16mul u_mul_acc (
    .i_a (acc),
    .i_b (sq),
    .o_p (mul_acc)
  );

  fp16mul u_mul_sq (
    .i_a (sq),
    .i_b (sq),
    .o_p (mul_sq)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sq_nxt    = sq;
    e_nxt     = e;
    res_nxt   = o_res;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          acc_nxt   = 16'h3C00;
          sq_nxt    = i_base;
          e_nxt     = i_exp;
          state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef FP16POW_ABORT_EN
        if (i_abort)
          state_nxt = IDLE;
        else
`endif
        if (e != '0) begin
          if (e[0])
            acc_nxt = mul_acc;
          sq_nxt = mul_sq;
          e_nxt  = e >> 1;
        end else begin
          res_nxt   = acc;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered copies of the upcoming state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      sq     <= '0;
      e      <= '0;
      o_res  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      sq     <= sq_nxt;
      e      <= e_nxt;
      o_res  <= res_nxt;
      o_busy <= (state_nxt != IDLE);
      o_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_fp16pow_seq.sv
// Randomized and directed bench for fp16pow_seq.
// Reference model: plain integer fp16 multiply chained by exponent bits.
module tb_fp16pow_seq;

  localparam int EW = 8;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [15:0]   i_base  = '0;
  logic [EW-1:0] i_exp   = '0;
`ifdef FP16POW_ABORT_EN
  logic          i_abort = 1'b0;
`endif
  logic          o_busy;
  logic          o_done;
  logic [15:0]   o_res;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  fp16pow_seq #(
    .EXP_WIDTH (EW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_base  (i_base),
    .i_exp   (i_exp),
`ifdef FP16POW_ABORT_EN
    .i_abort (i_abort),
`endif
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_res   (o_res)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b);
    int  ea, eb, fa, fb, m, ex;
    bit  s, za, zb, ia, ib, na, nb;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    fa = int'(a[9:0]);
    fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 31) && (fa == 0);
    ib = (eb == 31) && (fb == 0);
    na = (ea == 31) && (fa != 0);
    nb = (eb == 31) && (fb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return 16'h7E00;
    if (ia || ib) return {s, 15'h7C00};
    if (za || zb) return {s, 15'h0000};
    m  = (1024 + fa) * (1024 + fb);
    ex = ea + eb - 15;
    while (m >= (1 << 21)) begin
      m = m >> 1;
      ex++;
    end
    m = m >> 10;
    if (ex >= 31) return {s, 15'h7C00};
    if (ex <= 0) return {s, 15'h0000};
    return {s, 5'(ex), 10'(m - 1024)};
  endfunction

  function automatic logic [15:0] ref_pow(input logic [15:0] b,
                                          input int x);
    logic [15:0] acc, sq;
    int e;
    acc = 16'h3C00;
    sq  = b;
    e   = x;
    while (e != 0) begin
      if (e % 2 == 1) acc = ref_mul(acc, sq);
      sq = ref_mul(sq, sq);
      e  = e / 2;
    end
    return acc;
  endfunction

  function automatic int bitlen(input int x);
    int n = 0;
    while (x != 0) begin
      n++;
      x = x / 2;
    end
    return n;
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle
  task automatic run_op(input logic [15:0] b, input logic [EW-1:0] x,
                        input string tag);
    logic [15:0] want;
    int lat, busy_n, nb;
    want   = ref_pow(b, int'(x));
    nb     = bitlen(int'(x));
    lat    = -1;
    busy_n = 0;
    i_start = 1'b1;
    i_base  = b;
    i_exp   = x;
    for (int c = 1; c <= EW + 6; c++) begin
      @(posedge i_clk); #1;
      if (c == 1) begin
        i_start = 1'b0;
        i_base  = 16'($urandom);
        i_exp   = EW'($urandom);
      end
      if (o_busy) busy_n++;
      if (o_done) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".lat"}, lat, nb + 2);
    chk({tag, ".busy"}, busy_n, nb + 2);
    chk({tag, ".res"}, {16'd0, o_res}, {16'd0, want});
    @(posedge i_clk); #1;
    chk({tag, ".idle"}, {30'd0, o_busy, o_done}, 32'd0);
    chk({tag, ".hold"}, {16'd0, o_res}, {16'd0, want});
  endtask

  typedef struct {
    logic [15:0]   b;
    logic [EW-1:0] x;
    logic [15:0]   lit;
  } vec_t;

  vec_t dir[7] = '{
    '{16'h4000, 8'd3,  16'h4800},
    '{16'hC000, 8'd3,  16'hC800},
    '{16'h3E00, 8'd2,  16'h4080},
    '{16'h7E00, 8'd0,  16'h3C00},
    '{16'h0000, 8'd5,  16'h0000},
    '{16'h4000, 8'd16, 16'h7C00},
    '{16'h0400, 8'd2,  16'h0000}
  };

  initial begin
    int dn;
    logic [15:0] b;
    logic [EW-1:0] x;

    #2;
    chk("rst.busy", {31'd0, o_busy}, 32'd0);
    chk("rst.done", {31'd0, o_done}, 32'd0);
    chk("rst.res", {16'd0, o_res}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    foreach (dir[i]) begin
      run_op(dir[i].b, dir[i].x, $sformatf("dir%0d", i));
      chk($sformatf("dir%0d.lit", i), {16'd0, o_res}, {16'd0, dir[i].lit});
    end

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0)
        b = {1'($urandom), 5'($urandom_range(13, 17)), 10'($urandom)};
      else
        b = 16'($urandom);
      if (i % 3 == 0)
        x = EW'($urandom);
      else
        x = EW'($urandom_range(0, 15));
      run_op(b, x, $sformatf("rnd%0d", i));
    end

    // Start held high across two operations; only idle-cycle requests land
    dn = 0;
    i_start = 1'b1;
    i_base  = 16'h4000;
    i_exp   = 8'd3;
    for (int c = 1; c <= 12; c++) begin
      @(posedge i_clk); #1;
      if (c == 1) begin
        i_base = 16'h3E00;
        i_exp  = 8'd2;
      end
      if (o_done) begin
        dn++;
        if (dn == 1) chk("b2b.t1", c, 4);
        if (dn == 2) chk("b2b.t2", c, 9);
      end
      if (c == 5) begin
        chk("b2b.idle", {31'd0, o_busy}, 32'd0);
        chk("b2b.hold", {16'd0, o_res}, 32'h4800);
      end
      if (c == 9) i_start = 1'b0;
    end
    chk("b2b.cnt", dn, 2);
    chk("b2b.res", {16'd0, o_res}, {16'd0, ref_pow(16'h3E00, 2)});

`ifdef FP16POW_ABORT_EN
    run_op(16'h3E00, 8'd2, "pre");
    i_start = 1'b1;
    i_base  = 16'h4000;
    i_exp   = 8'd200;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    chk("abt.busy", {31'd0, o_busy}, 32'd0);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clk); #1;
      if (o_done) dn++;
    end
    chk("abt.nodone", dn, 0);
    chk("abt.res", {16'd0, o_res}, 32'h4080);
    i_start = 1'b1;
    i_abort = 1'b1;
    i_base  = 16'hC000;
    i_exp   = 8'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abt.acc", {31'd0, o_busy}, 32'd1);
    dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clk); #1;
      if (o_done) dn++;
    end
    chk("abt.done", dn, 1);
    chk("abt.res2", {16'd0, o_res}, 32'hC800);
`endif

    // Reset two cycles into a long run
    i_start = 1'b1;
    i_base  = 16'h4000;
    i_exp   = 8'd200;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("mrst.busy", {31'd0, o_busy}, 32'd0);
    chk("mrst.done", {31'd0, o_done}, 32'd0);
    chk("mrst.res", {16'd0, o_res}, 32'd0);
    @(posedge i_clk);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge i_clk); #1;
      if (o_done || o_busy) dn++;
    end
    chk("mrst.quiet", dn, 0);
    chk("mrst.res2", {16'd0, o_res}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
